// File: rtl/mem32_port_arbiter.sv
// mem32_port_arbiter
// Shares the single port of the 2048x32 program/data SRAM between the CPU
// fetch path (reads only) and the debug unit (read, single write, pair write).
// Grants are combinational in the access cycle. Read data returns one cycle
// after the grant.
//
// Optional feature: define MEM32_CLEAR_EN to zero the whole SRAM after every
// reset. The clear uses 1024 pair writes, and busy is high while it runs.
// Without the macro the clear logic is absent and busy is tied low.
module mem32_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        cpu_req,
  input  logic [10:0] cpu_addr,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_lock,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic        dbg_pair,
  input  logic [10:0] dbg_addr,
  input  logic [31:0] dbg_wdata1,
  input  logic [31:0] dbg_wdata2,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic        busy,
  output logic [10:0] mem_addr,
  output logic [10:0] mem_addr2,
  output logic [31:0] mem_din1,
  output logic [31:0] mem_din2,
  output logic        mem_wr_n,
  output logic        mem_hold,
  input  logic [31:0] mem_dout
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]  starve_reg;
  logic [10:0] addr_reg;
  logic        cpu_rvalid_reg;
  logic        dbg_rvalid_reg;
  logic [31:0] cpu_rdata_reg;
  logic [31:0] dbg_rdata_reg;

  logic        clearing;
  logic [10:0] clr_addr;
  logic        clear_wr;
  logic        starved;
  logic        dbg_win;
  logic        cpu_win;
  logic        pair_bad;
  logic        dbg_wr_ok;

`ifdef MEM32_CLEAR_EN
  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t      state_reg;
  logic [9:0]  clr_idx_reg;
  logic        busy_reg;

  // Clear sequencer: one zero pair write per cycle over the even addresses, then idle
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg   <= ST_CLEAR;
      clr_idx_reg <= 10'd0;
      busy_reg    <= 1'b1;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_idx_reg <= clr_idx_reg + 10'd1;
          if (clr_idx_reg == 10'd1023) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign clearing = (state_reg == ST_CLEAR);
  assign clr_addr = {clr_idx_reg, 1'b0};
  assign busy     = busy_reg;
`else
  assign clearing = 1'b0;
  assign clr_addr = 11'd0;
  assign busy     = 1'b0;
`endif

  // Arbitration and port drive for the current cycle. Reset masks every
  // grant and strobe, so a write that is in flight is aborted immediately.
  always_comb begin
    clear_wr  = clearing && !Rst;
    starved   = (starve_reg >= LIMIT);
    // Debug wins under lock, when it is the only requester, or while the CPU
    // has not yet waited STARVE_LIMIT cycles.
    dbg_win   = !Rst && !clearing && dbg_req &&
                (dbg_lock || !cpu_req || !starved);
    cpu_win   = !Rst && !clearing && cpu_req && !dbg_lock && !dbg_win;
    // Pairs must start on an even address. This also excludes the 2047->0 wrap.
    pair_bad  = dbg_win && dbg_we && dbg_pair && dbg_addr[0];
    dbg_wr_ok = dbg_win && dbg_we && !pair_bad;

    cpu_gnt   = cpu_win;
    dbg_gnt   = dbg_win;
    dbg_err   = pair_bad;

    if (clear_wr) begin
      mem_addr = clr_addr;
    end else if (dbg_win) begin
      mem_addr = dbg_addr;
    end else if (cpu_win) begin
      mem_addr = cpu_addr;
    end else begin
      mem_addr = addr_reg;
    end
    mem_addr2 = mem_addr + 11'd1;

    mem_wr_n  = !(dbg_wr_ok || clear_wr);
    mem_hold  = !(dbg_win || cpu_win || clear_wr);

    if (clear_wr) begin
      mem_din1 = 32'd0;
      mem_din2 = 32'd0;
    end else begin
      mem_din1 = dbg_wdata1;
      mem_din2 = (dbg_we && dbg_pair) ? dbg_wdata2 : dbg_wdata1;
    end
  end

  // Starve counter: counts cycles a pending CPU request loses, and saturates at the limit
  always_ff @(posedge Clk) begin
    if (Rst || clearing || dbg_lock || !cpu_req || cpu_win) begin
      starve_reg <= 8'd0;
    end else if (!starved) begin
      starve_reg <= starve_reg + 8'd1;
    end
  end

  // Remember the last address presented, so mem_addr holds steady in idle cycles
  always_ff @(posedge Clk) begin
    if (Rst) begin
      addr_reg <= 11'd0;
    end else if (!mem_hold) begin
      addr_reg <= mem_addr;
    end
  end

  // Read return: rvalid one cycle after a read grant; rdata holds the last returned word
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cpu_rvalid_reg <= 1'b0;
      dbg_rvalid_reg <= 1'b0;
      cpu_rdata_reg  <= 32'd0;
      dbg_rdata_reg  <= 32'd0;
    end else begin
      cpu_rvalid_reg <= cpu_win;
      dbg_rvalid_reg <= dbg_win && !dbg_we;
      if (cpu_rvalid_reg) begin
        cpu_rdata_reg <= mem_dout;
      end
      if (dbg_rvalid_reg) begin
        dbg_rdata_reg <= mem_dout;
      end
    end
  end

  assign cpu_rvalid = cpu_rvalid_reg;
  assign dbg_rvalid = dbg_rvalid_reg;
  assign cpu_rdata  = cpu_rvalid_reg ? mem_dout : cpu_rdata_reg;
  assign dbg_rdata  = dbg_rvalid_reg ? mem_dout : dbg_rdata_reg;

endmodule

// File: doc/mem32_port_arbiter.md
# mem32_port_arbiter

Sequencer and arbiter for the shared 2048x32 program/data SRAM. It shares the single memory port between the CPU fetch path (read-only) and the debug unit (read, single write, paired write). It generates the SRAM address, the active-low write strobe and the hold signal, and returns read data with a fixed one-cycle latency. It sits between the CPU/debug unit and the SRAM wrapper.

## Interface
- STARVE_LIMIT, 8: consecutive cycles a pending CPU request may lose to debug before it is forced through; range 1–255.
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU read request; held until granted.
- cpu_addr  in  11  CPU word address.
- cpu_gnt  out  1  request accepted this cycle.
- cpu_rvalid  out  1  cpu_rdata valid; pulses one cycle after cpu_gnt.
- cpu_rdata  out  32  read data.
- dbg_lock  in  1  debug owns the memory; the CPU is never granted while high.
- dbg_req  in  1  debug request; held until granted.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_pair  in  1  with dbg_we, write wdata1 to addr and wdata2 to addr+1.
- dbg_addr  in  11  debug word address.
- dbg_wdata1, dbg_wdata2  in  32 each  write data.
- dbg_gnt  out  1  request accepted this cycle.
- dbg_rvalid  out  1  dbg_rdata valid, one cycle after a read grant.
- dbg_rdata  out  32  read data.
- dbg_err  out  1  one-cycle pulse: pair write rejected.
- busy  out  1  high during CLEAR.
- mem_addr, mem_addr2  out  11 each  port-1 and port-2 word addresses; mem_addr2 = mem_addr+1 mod 2048.
- mem_din1, mem_din2  out  32 each  write data.
- mem_wr_n  out  1  active-low write strobe.
- mem_hold  out  1  high blocks SRAM access; drives the wrapper's enable_debug.
- mem_dout  in  32  SRAM port-1 read data, valid the cycle after the access.

## Operation
- States: CLEAR (present only with the macro), IDLE/ACCESS. One access per cycle; back-to-back grants are allowed.
- Arbitration in IDLE, each cycle:
  - dbg_req wins when dbg_lock=1, or when the starve counter is below STARVE_LIMIT.
  - Otherwise cpu_req wins.
  - A lone requester always wins, except that the CPU never wins while dbg_lock=1.
- Starve counter (8-bit):
  - Increments each cycle cpu_req=1 and the CPU is not granted.
  - Clears on cpu_gnt, or when cpu_req=0.
  - Saturates at STARVE_LIMIT.
  - Held at 0 while dbg_lock=1.
- Granted cycle:
  - mem_hold=0 and mem_addr = the granted address.
  - Write grants drive mem_wr_n=0.
  - Single write: drive mem_din1; mem_din2 = mem_din1.
  - Pair write: drives both data words.
- Pair write legality: dbg_addr must be even and at most 2046. An illegal pair still receives dbg_gnt, but mem_wr_n stays 1 and dbg_err pulses in the same cycle. The 2047→0 wrap is therefore never written.
- Idle cycles (no grant): mem_hold=1 and mem_wr_n=1; mem_addr holds its last value.
- Read return: the rvalid of the granted requester is registered high next cycle, and its rdata = mem_dout in that cycle. The other requester's rvalid stays 0.
- Simultaneous requests with equal eligibility: debug wins.

## Timing
- Reset values: cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, dbg_err = 0; mem_wr_n=1; mem_hold=1; mem_addr=0; rdata=0; starve counter=0.
- busy resets to 1 with the macro, 0 without.
- gnt is combinational from the req inputs and state, in the access cycle. rvalid follows gnt by exactly 1 cycle.
- Rst asserted mid-operation:
  - Suppresses any pending rvalid in the next cycle.
  - Aborts an in-flight write: mem_wr_n returns to 1 in the reset cycle.
  - Restarts CLEAR from address 0.
- Worst-case CPU wait with dbg_lock=0 and continuous debug traffic: STARVE_LIMIT+1 cycles.

## Configuration
- MEM32_CLEAR_EN defined:
  - After reset, the block enters CLEAR and issues pair writes of zero at even addresses 0,2,…,2046. This takes 1024 cycles, with mem_wr_n=0 and mem_hold=0.
  - No grants are issued and busy=1 during CLEAR.
  - Moves to IDLE after address 2046; busy falls the following cycle.
- Not defined: the CLEAR state is absent, busy is tied to 0, and arbitration starts the first cycle after reset.

## Test plan
- Reset then CPU read at 0x005 (SRAM holds 0xDEADBEEF): cpu_gnt in cycle t; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF at t+1; mem_wr_n=1 throughout.
- Debug pair write at 0x010 with 0x11111111/0x22222222, then reads at 0x010 and 0x011: the reads return those values; dbg_err=0.
- Pair write at 0x7FF and at 0x003: dbg_gnt=1 and dbg_err=1 for each; mem_wr_n stays 1; prior contents unchanged.
- Continuous dbg_req and cpu_req with dbg_lock=0, STARVE_LIMIT=8: cpu_gnt in the 9th cycle. With dbg_lock=1: no cpu_gnt for 100 cycles.
- Simultaneous first requests with the starve counter at 0: dbg_gnt only. Rst asserted in a grant cycle: no rvalid the next cycle.
- With MEM32_CLEAR_EN: busy=1 for 1024 cycles after reset; requests are ignored during that time; reads of 0x000, 0x3FF and 0x7FF return 0. Reset asserted at cycle 500 restarts the 1024-cycle count.
